riscv_wb_arbiter: RTL
=====================

Name: riscv_wb_arbiter

Overview:
- Write-side front end of the RI5CY flip-flop register file. Drives its two write ports (W1 `waddr_a/wdata_a/we_a`, W2 `waddr_b/wdata_b/we_b`).
- Accepts ALU writebacks, LSU writebacks through a small skid FIFO, and debug writes.
- Keeps a per-register pending scoreboard so decode can stall on RAW and WAW hazards against the three read addresses.
- Sits between the EX/LSU stages and the register file.

Parameters:
- `ADDR_WIDTH`, 5, register address width; `NUM_WORDS = 2**ADDR_WIDTH`.
- `DATA_WIDTH`, 32, register data width.
- `LSU_FIFO_DEPTH`, 2, LSU writeback buffer entries (power of two, ≥2).

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous active-low reset
- `issue_valid_i`  in  1  an instruction with destination `issue_rd_i` issues this cycle
- `issue_rd_i`  in  ADDR_WIDTH  destination of issuing instruction
- `raddr_a_i`, `raddr_b_i`, `raddr_c_i`  in  ADDR_WIDTH each  decode read addresses (mirror RF read ports)
- `hazard_o`  out  1  combinational; decode must stall
- `alu_valid_i`  in  1  ALU writeback; always accepted
- `alu_rd_i`  in  ADDR_WIDTH  ALU destination
- `alu_wdata_i`  in  DATA_WIDTH  ALU result
- `lsu_valid_i`  in  1  LSU writeback request
- `lsu_ready_o`  out  1  LSU writeback accepted when `valid & ready`
- `lsu_rd_i`  in  ADDR_WIDTH  LSU destination
- `lsu_wdata_i`  in  DATA_WIDTH  load data
- `dbg_we_i`  in  1  debug register write
- `dbg_waddr_i`  in  ADDR_WIDTH  debug address
- `dbg_wdata_i`  in  DATA_WIDTH  debug data
- `waddr_a_o`  out  ADDR_WIDTH  to RF W1
- `wdata_a_o`  out  DATA_WIDTH  to RF W1
- `we_a_o`  out  1  to RF W1
- `waddr_b_o`  out  ADDR_WIDTH  to RF W2
- `wdata_b_o`  out  DATA_WIDTH  to RF W2
- `we_b_o`  out  1  to RF W2
- `pending_o`  out  NUM_WORDS  scoreboard bits, for debug and assertions

Behaviour:

Reset
- `rst_n` low asynchronously clears:
  - all write outputs: `we_*=0`, `waddr_*=0`, `wdata_*=0`
  - FIFO pointers and count
  - all pending bits
- `lsu_ready_o` is 1 during and after reset.
- Reset mid-operation discards buffered LSU data. No write reaches the RF afterwards.

Port A (ALU path)
- Registered, one cycle. `alu_valid_i` at edge N drives `we_a_o=1` with the captured rd/data during cycle N+1.
- rd=0 is accepted but `we_a_o` stays 0.

Port B (debug and LSU path)
- Registered, one cycle. Each cycle selects in priority order:
  1. debug write
  2. FIFO head
  3. direct LSU bypass: FIFO empty and `lsu_valid_i & lsu_ready_o`
- LSU data that is not selected is pushed into the FIFO.
- Debug writes to x0 are suppressed.
- LSU order is preserved: strict FIFO, and the bypass is used only when the FIFO is empty.

FIFO flow control
- `lsu_ready_o = (count < LSU_FIFO_DEPTH)`.
- Push and pop in the same cycle leave count unchanged.
- Pointers wrap modulo DEPTH.
- Full: `lsu_ready_o=0`, the LSU holds its request.
- Empty with no debug write: bypass, FIFO untouched.

Scoreboard
- Set: `pending[rd]` is set at the edge where `issue_valid_i` and rd≠0.
- Clear: the bit is cleared at the edge ending the cycle in which a port A or port B write to rd is presented (`we_*_o=1`). This is the same edge at which the RF captures the data.
- Set and clear of the same register at the same edge: set wins.
- Debug writes never change pending.
- `pending[0]` is always 0.

Hazard
- `hazard_o = pending[raddr_a]|pending[raddr_b]|pending[raddr_c]`, plus `pending[issue_rd_i]` when `issue_valid_i`.
- Address 0 never contributes.
- There is no bypass. `hazard_o` drops the cycle after the RF write, when the RF already holds the data.

Simultaneous writes
- Port A and port B writing the same rd in one cycle cannot occur when decode honours `hazard_o`.
- If it does occur, the RF's W2 priority applies and both events clear the pending bit.

Test Plan:
1. Reset, then issue rd=5 and hold `raddr_a=5`.
   - `hazard_o=1`.
   - ALU writeback rd=5 data `0xDEADBEEF` at edge N: `we_a_o=1`, `waddr_a_o=5`, `wdata_a_o=0xDEADBEEF` in cycle N+1.
   - `hazard_o=0` and `pending_o[5]=0` from cycle N+2.
2. LSU writeback rd=7 `0x1234` with FIFO empty and no debug write → `we_b_o=1`, `waddr_b_o=7` next cycle; FIFO count stays 0.
3. `dbg_we_i` held for 4 cycles while the LSU streams rd=1,2,3:
   - `lsu_ready_o` drops after 2 accepts (FIFO full), and rd=3 is held.
   - After debug releases, port B emits rd=1, 2, 3 in consecutive cycles, in order.
4. ALU writeback rd=0 `0xFFFFFFFF` and debug write to x0 → `we_a_o=0`, `we_b_o=0`; `pending_o[0]=0`.
5. `issue_valid_i` rd=9 in the same cycle that port B presents a write to rd=9 → `pending_o[9]=1` afterwards (set wins). `issue_valid_i` rd=9 with `pending[9]` already set → `hazard_o=1` (WAW).
6. Assert `rst_n` low mid-cycle with the FIFO holding 2 entries and pending bits set → outputs, pending and count are 0 immediately; no `we_*_o` pulse follows the release of reset.

Source files
------------

// File: rtl/riscv_wb_arbiter.sv
// Write-side front end of the flip-flop register file: ALU on W1, debug/LSU on W2,
// with a small LSU skid FIFO and a per-register pending scoreboard for decode stalls.
module riscv_wb_arbiter #(
  parameter int ADDR_WIDTH     = 5,
  parameter int DATA_WIDTH     = 32,
  parameter int LSU_FIFO_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          issue_valid_i,
  input  logic [ADDR_WIDTH-1:0]         issue_rd_i,
  input  logic [ADDR_WIDTH-1:0]         raddr_a_i,
  input  logic [ADDR_WIDTH-1:0]         raddr_b_i,
  input  logic [ADDR_WIDTH-1:0]         raddr_c_i,
  output logic                          hazard_o,
  input  logic                          alu_valid_i,
  input  logic [ADDR_WIDTH-1:0]         alu_rd_i,
  input  logic [DATA_WIDTH-1:0]         alu_wdata_i,
  input  logic                          lsu_valid_i,
  output logic                          lsu_ready_o,
  input  logic [ADDR_WIDTH-1:0]         lsu_rd_i,
  input  logic [DATA_WIDTH-1:0]         lsu_wdata_i,
  input  logic                          dbg_we_i,
  input  logic [ADDR_WIDTH-1:0]         dbg_waddr_i,
  input  logic [DATA_WIDTH-1:0]         dbg_wdata_i,
  output logic [ADDR_WIDTH-1:0]         waddr_a_o,
  output logic [DATA_WIDTH-1:0]         wdata_a_o,
  output logic                          we_a_o,
  output logic [ADDR_WIDTH-1:0]         waddr_b_o,
  output logic [DATA_WIDTH-1:0]         wdata_b_o,
  output logic                          we_b_o,
  output logic [(2**ADDR_WIDTH)-1:0]    pending_o
);

  localparam int NUM_WORDS = 2 ** ADDR_WIDTH;
  localparam int PTR_W     = (LSU_FIFO_DEPTH > 1) ? $clog2(LSU_FIFO_DEPTH) : 1;
  localparam int CNT_W     = $clog2(LSU_FIFO_DEPTH + 1);

  logic [ADDR_WIDTH-1:0] fifo_rd   [LSU_FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data [LSU_FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count;

  logic                  fifo_nempty, lsu_fire, fifo_pop, fifo_push, bypass;
  logic                  b_sel, b_dbg, b_dbg_q;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [DATA_WIDTH-1:0] b_data;
  logic [NUM_WORDS-1:0]  pending, pending_nxt;

  function automatic logic pend_at(input logic [NUM_WORDS-1:0] p,
                                   input logic [ADDR_WIDTH-1:0] a);
    return (a != '0) && p[a];
  endfunction

  assign fifo_nempty = (count != '0);
  assign lsu_ready_o = (count < CNT_W'(LSU_FIFO_DEPTH));
  assign lsu_fire    = lsu_valid_i & lsu_ready_o;
  assign fifo_pop    = !dbg_we_i && fifo_nempty;
  // Bypass only when the FIFO is empty so LSU order is never reshuffled.
  assign bypass      = !dbg_we_i && !fifo_nempty && lsu_fire;
  assign fifo_push   = lsu_fire && !bypass;

  always_comb begin
    b_sel  = 1'b0;
    b_dbg  = 1'b0;
    b_addr = '0;
    b_data = '0;
    if (dbg_we_i) begin
      b_sel  = 1'b1;
      b_dbg  = 1'b1;
      b_addr = dbg_waddr_i;
      b_data = dbg_wdata_i;
    end else if (fifo_nempty) begin
      b_sel  = 1'b1;
      b_addr = fifo_rd[rd_ptr];
      b_data = fifo_data[rd_ptr];
    end else if (lsu_fire) begin
      b_sel  = 1'b1;
      b_addr = lsu_rd_i;
      b_data = lsu_wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_rd[wr_ptr]   <= lsu_rd_i;
      fifo_data[wr_ptr] <= lsu_wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (fifo_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (fifo_push && !fifo_pop)      count <= count + CNT_W'(1);
      else if (!fifo_push && fifo_pop) count <= count - CNT_W'(1);
    end
  end

  // Write ports: one registered stage each; x0 is never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_a_o    <= 1'b0;
      waddr_a_o <= '0;
      wdata_a_o <= '0;
      we_b_o    <= 1'b0;
      waddr_b_o <= '0;
      wdata_b_o <= '0;
      b_dbg_q   <= 1'b0;
    end else begin
      we_a_o <= alu_valid_i && (alu_rd_i != '0);
      if (alu_valid_i) begin
        waddr_a_o <= alu_rd_i;
        wdata_a_o <= alu_wdata_i;
      end
      we_b_o    <= b_sel && (b_addr != '0);
      waddr_b_o <= b_addr;
      wdata_b_o <= b_data;
      b_dbg_q   <= b_dbg;
    end
  end

  // Clears come from writes presented this cycle; a same-edge issue re-sets the bit.
  always_comb begin
    pending_nxt = pending;
    if (we_a_o)             pending_nxt[waddr_a_o] = 1'b0;
    if (we_b_o && !b_dbg_q) pending_nxt[waddr_b_o] = 1'b0;
    if (issue_valid_i)      pending_nxt[issue_rd_i] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= pending_nxt;
  end

  assign pending_o = pending;
  assign hazard_o  = pend_at(pending, raddr_a_i) | pend_at(pending, raddr_b_i) |
                     pend_at(pending, raddr_c_i) |
                     (issue_valid_i && pend_at(pending, issue_rd_i));

endmodule
